// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit path.
//   uart_tx_state_t : transmit FSM state encoding
//   UART_IDLE_LEVEL : line level while no frame is being sent
//   uart_parity()   : parity over up to 9 data bits (zero-extend narrower words)
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Zero bits do not change XOR parity, so narrower words can be zero-extended.
   function automatic logic uart_parity(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer for the UART transmitter.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-high reset
//   run     in  count while high; counter held at 0 while low
//   bit_end out high in the last cycle of each bit period (count == CLKS_PER_BIT-1)
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic bit_end
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CntW-1:0] cnt_q;

   assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (reset || !run) begin
         cnt_q <= '0;
      end else if (bit_end) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit serializer. Accepts a DATA_W-bit word on a valid/ready
// handshake and sends start bit, data LSB first, optional parity bit and STOP_BITS stop
// bits on a single registered line.
// Build option: define UART_TX_PARITY_EN to add the parity bit (even, or odd when
// PARITY_ODD=1). Without it the frame has no parity bit and PARITY_ODD is ignored.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset; aborts any frame in progress
//   tx_valid in  tx_data holds a word to send
//   tx_data  in  word to send, sampled only when accepted
//   tx_ready out block accepts a word this cycle (registered)
//   busy     out frame in progress (registered)
//   tx_out   out serial line, idle high (registered)
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              busy,
   output logic              tx_out
);

   if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
      $error("uart_tx_serializer: DATA_W must be 5..9");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD > 1) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
   end

   localparam int unsigned IdxW = $clog2(DATA_W);

   uart_tx_state_t    state_q;
   logic [DATA_W-1:0] shift_q;
   logic [IdxW-1:0]   bit_idx_q;
   logic              tx_out_q;
   logic              tx_ready_q;
   logic              busy_q;
   logic              bit_end;
`ifdef UART_TX_PARITY_EN
   logic              par_q;
`endif

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk    (clk),
      .reset  (reset),
      .run    (state_q != IDLE),
      .bit_end(bit_end)
   );

   // Outputs are loaded together with the state they belong to, so each register
   // already holds the level for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         tx_out_q   <= UART_IDLE_LEVEL;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (tx_valid) begin
                  state_q    <= START;
                  shift_q    <= tx_data;
                  bit_idx_q  <= '0;
                  tx_out_q   <= 1'b0;
                  tx_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                  par_q      <= uart_parity(9'(tx_data), PARITY_ODD[0]);
`endif
               end
            end
            START: begin
               if (bit_end) begin
                  state_q   <= DATA;
                  bit_idx_q <= '0;
                  tx_out_q  <= shift_q[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx_q == IdxW'(DATA_W - 1)) begin
                     bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                     state_q   <= PARITY;
                     tx_out_q  <= par_q;
`else
                     state_q   <= STOP;
                     tx_out_q  <= UART_IDLE_LEVEL;
`endif
                  end else begin
                     // Next bit is shift_q[1]; it lands in shift_q[0] after the shift.
                     shift_q   <= shift_q >> 1;
                     tx_out_q  <= shift_q[1];
                     bit_idx_q <= bit_idx_q + IdxW'(1);
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state_q   <= STOP;
                  bit_idx_q <= '0;
                  tx_out_q  <= UART_IDLE_LEVEL;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  if (bit_idx_q == IdxW'(STOP_BITS - 1)) begin
                     state_q    <= IDLE;
                     bit_idx_q  <= '0;
                     tx_ready_q <= 1'b1;
                     busy_q     <= 1'b0;
                  end else begin
                     bit_idx_q <= bit_idx_q + IdxW'(1);
                  end
               end
            end
            default: begin
               state_q    <= IDLE;
               bit_idx_q  <= '0;
               tx_out_q   <= UART_IDLE_LEVEL;
               tx_ready_q <= 1'b1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign tx_out   = tx_out_q;
   assign tx_ready = tx_ready_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: self-checking bench for uart_tx_serializer.
// dut0: DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1, PARITY_ODD=0.
// dut1: same but STOP_BITS=2, PARITY_ODD=1.
// Expected line waveforms are built from the frame definition (start, data LSB first,
// optional parity, stop bits), each bit repeated for one bit period.
module tb_uart_tx_serializer;

   localparam int unsigned Cpb = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit ParEn = 1'b1;
`else
   localparam bit ParEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] valid;
   logic [7:0] data0;
   logic [7:0] data1;
   logic [1:0] rdy;
   logic [1:0] bsy;
   logic [1:0] txo;

   int n_checks = 0;
   int n_fail   = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   uart_tx_serializer #(
      .DATA_W(8), .CLKS_PER_BIT(Cpb), .STOP_BITS(1), .PARITY_ODD(0)
   ) dut0 (
      .clk     (clk),
      .reset   (reset),
      .tx_valid(valid[0]),
      .tx_data (data0),
      .tx_ready(rdy[0]),
      .busy    (bsy[0]),
      .tx_out  (txo[0])
   );

   uart_tx_serializer #(
      .DATA_W(8), .CLKS_PER_BIT(Cpb), .STOP_BITS(2), .PARITY_ODD(1)
   ) dut1 (
      .clk     (clk),
      .reset   (reset),
      .tx_valid(valid[1]),
      .tx_data (data1),
      .tx_ready(rdy[1]),
      .busy    (bsy[1]),
      .tx_out  (txo[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic [7:0] d);
      valid[sel] = v;
      if (sel == 1) data1 = d;
      else data0 = d;
   endtask

   // Reference frame: list of line levels, one per clock cycle.
   task automatic build_frame(input logic [7:0] d, input int stops, input bit odd);
      bit bits[$];
      exp_q.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (ParEn) bits.push_back((($countones(d) % 2) == 1) ^ odd);
      for (int i = 0; i < stops; i++) bits.push_back(1'b1);
      foreach (bits[i]) repeat (Cpb) exp_q.push_back(bits[i]);
   endtask

   task automatic check_idle(input int sel, input string tag);
      check_eq({tag, "_tx"}, 32'(txo[sel]), 32'd1);
      check_eq({tag, "_ready"}, 32'(rdy[sel]), 32'd1);
      check_eq({tag, "_busy"}, 32'(bsy[sel]), 32'd0);
   endtask

   // Called at +1 in a cycle where the selected DUT is idle. Returns at +1 in the
   // first idle cycle after the frame. hold keeps tx_valid high with next_d.
   task automatic send_frame(input int sel, input logic [7:0] d, input bit noise,
                             input bit hold, input logic [7:0] next_d);
      int n;
      build_frame(d, (sel == 1) ? 2 : 1, sel == 1);
      n = exp_q.size();
      check_eq("ready_pre", 32'(rdy[sel]), 32'd1);
      drive(sel, 1'b1, d);
      tick(1);
      if (hold) drive(sel, 1'b1, next_d);
      else drive(sel, 1'b0, 8'($urandom));
      for (int k = 0; k < n; k++) begin
         check_eq($sformatf("line_c%0d", k + 1), 32'(txo[sel]), 32'(exp_q[k]));
         check_eq("busy_frame", 32'(bsy[sel]), 32'd1);
         check_eq("ready_frame", 32'(rdy[sel]), 32'd0);
         if (noise) drive(sel, (k == n - 1) ? 1'b0 : 1'($urandom_range(0, 1)), 8'($urandom));
         tick(1);
      end
      check_idle(sel, "post");
   endtask

   initial begin
      logic [7:0] d;
      reset = 1'b1;
      valid = '0;
      data0 = '0;
      data1 = '0;

      // Reset, then hold idle.
      tick(2);
      check_idle(0, "rst0");
      check_idle(1, "rst1");
      reset = 1'b0;
      for (int i = 0; i < 20; i++) check_idle(0, "hold");

      for (int i = 0; i < 20; i++) begin
         check_idle(0, "hold_idle");
         tick(1);
      end

      // Directed frames.
      send_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00);
      tick(1);
      send_frame(1, 8'h01, 1'b0, 1'b0, 8'h00);
      tick(2);
      send_frame(1, 8'h03, 1'b0, 1'b0, 8'h00);
      tick(1);

      // Back-to-back: the idle check inside send_frame covers the single gap cycle.
      send_frame(0, 8'h00, 1'b0, 1'b1, 8'hFF);
      send_frame(0, 8'hFF, 1'b0, 1'b0, 8'h00);
      tick(1);

      // Inputs toggled while busy.
      send_frame(0, 8'h5A, 1'b1, 1'b0, 8'h00);
      tick(1);

      // Reset in the middle of a data bit (cycle t+15).
      build_frame(8'hC3, 1, 1'b0);
      drive(0, 1'b1, 8'hC3);
      tick(1);
      drive(0, 1'b0, 8'h00);
      for (int k = 0; k < 15; k++) begin
         check_eq($sformatf("abort_c%0d", k + 1), 32'(txo[0]), 32'(exp_q[k]));
         if (k == 14) reset = 1'b1;
         tick(1);
      end
      check_idle(0, "abort");
      reset = 1'b0;
      tick(1);
      send_frame(0, 8'h96, 1'b0, 1'b0, 8'h00);

      // Randomized frames on both instances.
      for (int i = 0; i < 24; i++) begin
         int sel;
         sel = int'($urandom_range(0, 1));
         d = 8'($urandom);
         tick(int'($urandom_range(0, 3)));
         send_frame(sel, d, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
